// File: rtl/icache_pkg.sv
// icache_pkg: shared FSM state type, address-split widths and default nop for the instruction cache
package icache_pkg;
  typedef enum logic {IDLE, FILL} state_t;
  localparam logic [31:0] RESET_INSTRUCTION_DEFAULT = 32'h0000_0000;
  function automatic int offset_w(input int line_words);
    return $clog2(line_words);
  endfunction
  function automatic int index_w(input int num_lines);
    return $clog2(num_lines);
  endfunction
  function automatic int tag_w(input int num_lines, input int line_words);
    return 30 - $clog2(num_lines) - $clog2(line_words);
  endfunction
endpackage

// File: rtl/instruction_cache_if.sv
// instruction_cache_if: fetch-side lookup and memory fill handshake of the instruction cache
interface instruction_cache_if;
  logic [31:0] PC;
  logic [31:0] instruction;
  logic        hit;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_data;
  modport master (input PC, mem_ready, mem_data, output instruction, hit, mem_req, mem_addr);
  modport slave (output PC, mem_ready, mem_data, input instruction, hit, mem_req, mem_addr);
endinterface

// File: rtl/icache_data_array.sv
// icache_data_array: line storage with asynchronous (index, word) read and synchronous write
module icache_data_array #(
  parameter int NUM_LINES  = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [$clog2(NUM_LINES)-1:0]  w_idx,
  input  logic [$clog2(LINE_WORDS)-1:0] w_word,
  input  logic [31:0]                   w_data,
  input  logic [$clog2(NUM_LINES)-1:0]  r_idx,
  input  logic [$clog2(LINE_WORDS)-1:0] r_word,
  output logic [31:0]                   r_data
);
  logic [31:0] mem [NUM_LINES*LINE_WORDS];
  assign r_data = mem[{r_idx, r_word}];
  always_ff @(posedge clk)
    if (we) mem[{w_idx, w_word}] <= w_data;
endmodule

// File: rtl/instruction_cache.sv
// instruction_cache: direct-mapped read-only I-cache with line-fill FSM; hit=0 stalls the pipeline
// Optional ICACHE_PERF_COUNTERS_EN adds hit_count/miss_count outputs.
module instruction_cache
  import icache_pkg::*;
#(
  parameter int          NUM_LINES         = 16,
  parameter int          LINE_WORDS        = 4,
  parameter logic [31:0] RESET_INSTRUCTION = RESET_INSTRUCTION_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  instruction_cache_if.master bus
`ifdef ICACHE_PERF_COUNTERS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);
  localparam int OW = offset_w(LINE_WORDS);
  localparam int IW = index_w(NUM_LINES);
  localparam int TW = tag_w(NUM_LINES, LINE_WORDS);
  state_t state_q, state_d;
  logic [OW-1:0] pc_word, cnt_q, cnt_d;
  logic [IW-1:0] pc_idx, fill_idx_q, fill_idx_d;
  logic [TW-1:0] pc_tag, fill_tag_q, fill_tag_d;
  logic [TW-1:0] tag_q [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic hit, we, last;
  logic [31:0] rdata;
  assign pc_word = bus.PC[2+:OW];
  assign pc_idx  = bus.PC[2+OW+:IW];
  assign pc_tag  = bus.PC[31-:TW];
  assign hit  = state_q == IDLE && valid_q[pc_idx] && tag_q[pc_idx] == pc_tag;
  assign we   = state_q == FILL && bus.mem_ready;
  assign last = we && cnt_q == OW'(LINE_WORDS - 1);
  assign bus.hit         = hit;
  assign bus.instruction = hit ? rdata : RESET_INSTRUCTION;
  assign bus.mem_req     = state_q == FILL;
  assign bus.mem_addr    = state_q == FILL ? {fill_tag_q, fill_idx_q, cnt_q, 2'b00} : '0;
  icache_data_array #(.NUM_LINES(NUM_LINES), .LINE_WORDS(LINE_WORDS)) u_data (
    .clk(clock), .we(we), .w_idx(fill_idx_q), .w_word(cnt_q), .w_data(bus.mem_data),
    .r_idx(pc_idx), .r_word(pc_word), .r_data(rdata)
  );
  // Tag/index are latched on every IDLE cycle; only the one taken on a miss matters.
  always_comb begin
    state_d    = state_q == IDLE && !hit ? FILL : last ? IDLE : state_q;
    fill_tag_d = state_q == IDLE ? pc_tag : fill_tag_q;
    fill_idx_d = state_q == IDLE ? pc_idx : fill_idx_q;
    cnt_d      = state_q == IDLE ? '0 : we ? cnt_q + 1'b1 : cnt_q;
    valid_d    = valid_q;
    if (last) valid_d[fill_idx_q] = 1'b1;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      cnt_q      <= '0;
      fill_tag_q <= '0;
      fill_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      cnt_q      <= cnt_d;
      fill_tag_q <= fill_tag_d;
      fill_idx_q <= fill_idx_d;
    end
  end
  always_ff @(posedge clock)
    if (last) tag_q[fill_idx_q] <= fill_tag_q;
`ifdef ICACHE_PERF_COUNTERS_EN
  logic [31:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;
  always_comb begin
    hit_count_d  = hit ? hit_count_q + 32'd1 : hit_count_q;
    miss_count_d = state_q == IDLE && !hit ? miss_count_q + 32'd1 : miss_count_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif
endmodule

// File: tb/tb_instruction_cache.sv
// tb_instruction_cache: directed checks of lookup, fill timing, conflicts, stalls and reset abort
module tb_instruction_cache;
  logic clock = 1'b0;
  logic reset;
  logic [31:0] k;
  int pass_n = 0, total_n = 0, fail_n = 0;
  instruction_cache_if bus();
  always #5 clock = ~clock;
  assign bus.mem_data = bus.mem_addr ^ k;
`ifdef ICACHE_PERF_COUNTERS_EN
  logic [31:0] hit_count, miss_count;
  instruction_cache dut (.clock(clock), .reset(reset), .bus(bus), .hit_count(hit_count), .miss_count(miss_count));
`else
  instruction_cache dut (.clock(clock), .reset(reset), .bus(bus));
`endif
  task automatic tick();
    @(posedge clock);
    #2;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_n++;
    assert (obs === exp) pass_n++;
    else begin
      fail_n++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic run_fill(input logic [31:0] base, input logic [31:0] exp_instr);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("fill_addr", bus.mem_addr, base + 32'(4 * i));
      chk("fill_req", {31'b0, bus.mem_req}, 32'd1);
      chk("fill_hit", {31'b0, bus.hit}, 32'd0);
      chk("fill_instr", bus.instruction, 32'h0);
    end
    tick();
    chk("done_hit", {31'b0, bus.hit}, 32'd1);
    chk("done_req", {31'b0, bus.mem_req}, 32'd0);
    chk("done_instr", bus.instruction, exp_instr);
  endtask
  initial begin
    logic [6:0] pat;
    int w;
    k = 32'hA5A5A5A5;
    reset = 1'b1;
    bus.PC = 32'h0;
    bus.mem_ready = 1'b0;
    tick();
    tick();
    chk("rst_hit", {31'b0, bus.hit}, 32'd0);
    chk("rst_req", {31'b0, bus.mem_req}, 32'd0);
    chk("rst_addr", bus.mem_addr, 32'h0);
    chk("rst_instr", bus.instruction, 32'h0);
`ifdef ICACHE_PERF_COUNTERS_EN
    chk("rst_hit_count", hit_count, 32'd0);
    chk("rst_miss_count", miss_count, 32'd0);
`endif
    reset = 1'b0;
    bus.PC = 32'h40;
    bus.mem_ready = 1'b1;
    #1;
    chk("miss0_hit", {31'b0, bus.hit}, 32'd0);
    chk("miss0_req", {31'b0, bus.mem_req}, 32'd0);
    run_fill(32'h40, 32'hA5A5A5E5);
    bus.PC = 32'h48;
    #1;
    chk("same_line_hit", {31'b0, bus.hit}, 32'd1);
    chk("same_line_instr", bus.instruction, 32'hA5A5A5ED);
    chk("same_line_req", {31'b0, bus.mem_req}, 32'd0);
    bus.PC = 32'h140;
    #1;
    chk("conflict_miss", {31'b0, bus.hit}, 32'd0);
    run_fill(32'h140, 32'hA5A5A4E5);
    bus.PC = 32'h40;
    #1;
    chk("evicted_miss", {31'b0, bus.hit}, 32'd0);
    run_fill(32'h40, 32'hA5A5A5E5);
    pat = 7'b1011001;
    w = 0;
    bus.PC = 32'h80;
    bus.mem_ready = 1'b0;
    #1;
    chk("pat_miss", {31'b0, bus.hit}, 32'd0);
    for (int i = 0; i < 7; i++) begin
      tick();
      bus.mem_ready = pat[i];
      #1;
      chk("pat_req", {31'b0, bus.mem_req}, 32'd1);
      chk("pat_hit", {31'b0, bus.hit}, 32'd0);
      chk("pat_addr", bus.mem_addr, 32'h80 + 32'(4 * w));
      if (pat[i]) w++;
    end
    tick();
    chk("pat_done_hit", {31'b0, bus.hit}, 32'd1);
    chk("pat_done_instr", bus.instruction, 32'hA5A5A525);
    bus.PC = 32'h8C;
    bus.mem_ready = 1'b1;
    tick();
    chk("idle_ready_req", {31'b0, bus.mem_req}, 32'd0);
    chk("pat_last_word", bus.instruction, 32'hA5A5A529);
    bus.PC = 32'hC0;
    #1;
    chk("abort_miss", {31'b0, bus.hit}, 32'd0);
    tick();
    tick();
    chk("abort_c2_addr", bus.mem_addr, 32'hC4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.PC = 32'h40;
    #1;
    chk("post_abort_hit", {31'b0, bus.hit}, 32'd0);
    chk("post_abort_req", {31'b0, bus.mem_req}, 32'd0);
    chk("post_abort_addr", bus.mem_addr, 32'h0);
    run_fill(32'h40, 32'hA5A5A5E5);
    bus.PC = 32'hFFFF_FFFC;
    #1;
    chk("top_miss", {31'b0, bus.hit}, 32'd0);
    run_fill(32'hFFFF_FFF0, 32'h5A5A5A59);
    bus.PC = 32'h100;
    #1;
    tick();
    chk("pcchg_addr0", bus.mem_addr, 32'h100);
    bus.PC = 32'h210;
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("pcchg_addr", bus.mem_addr, 32'h100 + 32'(4 * i));
    end
    tick();
    chk("pcchg_idle_hit", {31'b0, bus.hit}, 32'd0);
    chk("pcchg_idle_req", {31'b0, bus.mem_req}, 32'd0);
    run_fill(32'h210, 32'hA5A5A7B5);
    bus.PC = 32'h104;
    #1;
    chk("pcchg_old_line", bus.instruction, 32'hA5A5A4A1);
`ifdef ICACHE_PERF_COUNTERS_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.PC = 32'h40;
    for (int i = 0; i < 5; i++) tick();
    tick();
    tick();
    tick();
    chk("perf_miss_count", miss_count, 32'd1);
    chk("perf_hit_count", hit_count, 32'd3);
`endif
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
